// File: rtl/uart_reg_bank_pkg.sv
// Shared constants and read-handshake state encoding for the UART register bank.
package uart_reg_bank_pkg;

  localparam int unsigned C_ADR_W   = 4;
  localparam int unsigned C_DAT_W   = 8;
  localparam int unsigned C_DEPTH   = 2 ** C_ADR_W;
  localparam int unsigned C_RO_BASE = 12;
  localparam int unsigned C_STAT_N  = C_DEPTH - C_RO_BASE;
  localparam int unsigned C_RD_LAT  = 2;
  localparam int unsigned C_CNT_W   = 4;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_ACK  = 2'd2,
    RD_DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/uart_reg_bank_rd_handshake.sv
// Four-phase read handshake: fixed-latency ack, data captured at ack time and
// frozen until the request drops.
module uart_reg_bank_rd_handshake
  import uart_reg_bank_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_req,
  input  logic [C_DAT_W-1:0] rd_data_c,
  output logic               rd_ack,
  output logic [C_DAT_W-1:0] rd_dat
);

  rd_state_e          state;
  logic [C_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RD_IDLE;
      cnt    <= '0;
      rd_ack <= 1'b0;
      rd_dat <= '0;
    end else begin
      case (state)
        RD_IDLE: begin
          if (rd_req) begin
            cnt   <= C_CNT_W'(C_RD_LAT - 1);
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A dropped request wins over an expiring counter: no ack on abort.
          if (!rd_req) begin
            state <= RD_IDLE;
          end else if (cnt == '0) begin
            rd_dat <= rd_data_c;
            rd_ack <= 1'b1;
            state  <= RD_ACK;
          end else begin
            cnt <= cnt - C_CNT_W'(1);
          end
        end
        RD_ACK: begin
          if (!rd_req) begin
            rd_ack <= 1'b0;
            state  <= RD_DONE;
          end
        end
        RD_DONE: state <= RD_IDLE;
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_bank.sv
// Shadowed register bank behind the UART parser: writes go to shadow, frame
// sync commits shadow to active, upper addresses read live status.
module uart_reg_bank
  import uart_reg_bank_pkg::*;
(
  input  logic                          CK_i,
  input  logic                          XARST_i,
  input  logic [7:0]                    ADRs_i,
  input  logic [C_DAT_W-1:0]            WDATs_i,
  input  logic                          WT_REQ_i,
  input  logic                          RD_REQ_i,
  output logic                          RD_ACK_o,
  output logic [C_DAT_W-1:0]            RDATs_o,
  input  logic                          VSYNC_i,
  input  logic [C_STAT_N*C_DAT_W-1:0]   STATs_i,
  output logic [C_RO_BASE*C_DAT_W-1:0]  REGs_o,
  output logic                          COMMIT_o,
  output logic                          DIRTY_o
);

  logic [C_DAT_W-1:0] shadow [C_RO_BASE];
  logic [C_DAT_W-1:0] active [C_RO_BASE];
  logic               vsync_d;

  logic [C_ADR_W-1:0] adr_lo_c;
  logic               in_range_c;
  logic               is_rw_c;
  logic               is_ro_c;
  logic               wr_c;
  logic               vsync_rise_c;
  logic               commit_c;
  logic [C_DAT_W-1:0] rd_data_c;

  assign adr_lo_c     = ADRs_i[C_ADR_W-1:0];
  assign in_range_c   = (ADRs_i[7:C_ADR_W] == '0);
  assign is_rw_c      = in_range_c && (adr_lo_c < C_ADR_W'(C_RO_BASE));
  assign is_ro_c      = in_range_c && !is_rw_c;
  assign wr_c         = WT_REQ_i && is_rw_c;
  assign vsync_rise_c = VSYNC_i && !vsync_d;
  assign commit_c     = vsync_rise_c && DIRTY_o;

  // Commit copies the pre-write shadow; a same-cycle write stays dirty.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      for (int i = 0; i < int'(C_RO_BASE); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      vsync_d  <= 1'b0;
      COMMIT_o <= 1'b0;
      DIRTY_o  <= 1'b0;
    end else begin
      vsync_d  <= VSYNC_i;
      COMMIT_o <= commit_c;
      for (int i = 0; i < int'(C_RO_BASE); i++) begin
        if (wr_c && (adr_lo_c == C_ADR_W'(i))) shadow[i] <= WDATs_i;
        if (commit_c) active[i] <= shadow[i];
      end
      if (wr_c) DIRTY_o <= 1'b1;
      else if (commit_c) DIRTY_o <= 1'b0;
    end
  end

  // Out-of-range reads return zero but are still acknowledged.
  always_comb begin
    rd_data_c = '0;
    if (is_rw_c) begin
      for (int i = 0; i < int'(C_RO_BASE); i++) begin
        if (adr_lo_c == C_ADR_W'(i)) rd_data_c = shadow[i];
      end
    end else if (is_ro_c) begin
      for (int k = 0; k < int'(C_STAT_N); k++) begin
        if (adr_lo_c == C_ADR_W'(int'(C_RO_BASE) + k)) rd_data_c = STATs_i[k*C_DAT_W +: C_DAT_W];
      end
    end
  end

  for (genvar n = 0; n < int'(C_RO_BASE); n++) begin : g_regs
    assign REGs_o[n*C_DAT_W +: C_DAT_W] = active[n];
  end

  uart_reg_bank_rd_handshake u_rd (
    .clk       (CK_i),
    .rst_n     (XARST_i),
    .rd_req    (RD_REQ_i),
    .rd_data_c (rd_data_c),
    .rd_ack    (RD_ACK_o),
    .rd_dat    (RDATs_o)
  );

endmodule

// File: doc/uart_reg_bank.md
Name: uart_reg_bank

Overview:
- Register bank directly downstream of the UART command parser. It consumes the parser's write strobes and serves its read request/acknowledge handshake.
- Writes land in shadow registers. Shadow contents are committed to the active set on a frame-boundary pulse, so video/font logic never sees a half-updated register set mid-frame.
- Upper address range is read-only and maps live status inputs.

Parameters:
- C_ADR_W, 4: address bits decoded; bank depth = 2**C_ADR_W = 16.
- C_DAT_W, 8: register width.
- C_RO_BASE, 12: first read-only (status) address; addresses C_RO_BASE..2**C_ADR_W-1 are status.
- C_RD_LAT, 2: cycles from RD_REQ_i rise to RD_ACK_o rise (legal range 1..15).

Ports:
- CK_i  in  1  clock.
- XARST_i  in  1  async reset, active low.
- ADRs_i  in  8  register address from parser.
- WDATs_i  in  C_DAT_W  write data.
- WT_REQ_i  in  1  1-cycle write strobe, no ack.
- RD_REQ_i  in  1  read request, level, held until ack seen.
- RD_ACK_o  out  1  read acknowledge, level.
- RDATs_o  out  C_DAT_W  read data, valid and stable while RD_ACK_o=1.
- VSYNC_i  in  1  frame sync, synchronous to CK_i.
- STATs_i  in  (2**C_ADR_W-C_RO_BASE)*C_DAT_W  status words, flat, word k at address C_RO_BASE+k.
- REGs_o  out  C_RO_BASE*C_DAT_W  active register set, flat, word n = address n.
- COMMIT_o  out  1  1-cycle pulse when shadow was copied to active.
- DIRTY_o  out  1  shadow differs-by-write since last commit.

Behaviour:
Reset (async, XARST_i=0):
- All shadow and active registers clear to 0.
- RD_ACK_o=0, RDATs_o=0, COMMIT_o=0, DIRTY_o=0.
- Read FSM to IDLE; VSYNC edge register to 0.
- Reset mid-read aborts the read with no ack.

Address decode:
- In range: ADRs_i[7:C_ADR_W]==0.
- RW: in range and low bits < C_RO_BASE.
- RO: in range and low bits >= C_RO_BASE.

Write:
- On WT_REQ_i=1 with RW address: shadow[adr] <= WDATs_i next edge; DIRTY_o <= 1.
- RO or out-of-range writes are ignored; DIRTY_o is unchanged.

Commit:
- VSYNC rise = VSYNC_i & ~VSYNC_d.
- On VSYNC rise with DIRTY_o=1: active <= shadow (all words); COMMIT_o=1 for one cycle; DIRTY_o <= 0.
- On VSYNC rise with DIRTY_o=0: no action, no pulse.
- Write and VSYNC rise in the same cycle: active gets the pre-write shadow, the write lands in shadow, and DIRTY_o stays 1 (the next frame commits it).

Read FSM (4-phase handshake):
- IDLE: RD_REQ_i=1 -> load counter with C_RD_LAT-1, go to WAIT.
- WAIT: counter decrements each cycle. RD_REQ_i=0 -> IDLE (abort, no ack). Counter==0 -> capture RDATs_o, RD_ACK_o <= 1, go to ACK.
- Captured read data:
  - RW address: shadow[adr].
  - RO address: STATs_i word.
  - Out of range: 0x00, still acked to avoid a parser hang.
- ACK: RDATs_o frozen. RD_REQ_i=0 -> RD_ACK_o <= 0, go to DONE.
- DONE: one cycle; then IDLE. This guarantees ACK low is seen before the next request is accepted.
- Net timing: RD_ACK_o rises exactly C_RD_LAT cycles after the first cycle RD_REQ_i=1 is sampled. It falls 1 cycle after RD_REQ_i=0 is sampled.
- Data is taken at ack time, so a write to the same address during WAIT is reflected in the read.
- ADRs_i is sampled at the capture cycle; the parser holds it stable during a read.

Width rules:
- Counter width 4.
- Status and register words are indexed with constant-width slices; no arithmetic overflow paths.

Decomposition:
- Shared defines/package: bank depth, C_RO_BASE, and read FSM state encodings (IDLE=0, WAIT=1, ACK=2, DONE=3) go with the existing misc defines.
- One natural sub-module: reg_rd_handshake. It holds the read FSM, latency counter, and ack/data capture, taking a combinational read-data mux input.
- The bank top owns shadow/active arrays, the write path, and commit logic.

Test Plan:
- Write 0x5A to adr 3, no VSYNC -> shadow[3]=0x5A, REGs_o word3 still 0x00, DIRTY_o=1; VSYNC pulse -> next cycle word3=0x5A, COMMIT_o one-cycle pulse, DIRTY_o=0.
- Read adr 3 (C_RD_LAT=2) -> RD_ACK_o high 2 cycles after RD_REQ_i, RDATs_o=0x5A held until RD_REQ_i drops, ack low 1 cycle later.
- Read adr 0xC with STATs_i word0=0xA5 -> RDATs_o=0xA5; write 0x11 to 0xC -> ignored, DIRTY_o unchanged.
- Write to adr 0x13 (out of range) -> no change; read 0x13 -> ack with 0x00.
- Write adr 1 in the same cycle as VSYNC rise -> active word1 keeps old value, DIRTY_o=1; next VSYNC commits the new value.
- Drop RD_REQ_i during WAIT, then assert XARST_i mid-ACK -> no ack on abort; reset forces RD_ACK_o=0, RDATs_o=0, all regs 0.
